// File: rtl/div_unit_if.sv
// EX-stage divide handshake: EX drives the request side (master), the divider
// answers with result_o/ready_o (slave).
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic                   signed_div_i;
    logic [WIDTH-1:0]       opdata1_i;
    logic [WIDTH-1:0]       opdata2_i;
    logic                   start_i;
    logic                   annul_i;
    logic [2*WIDTH-1:0]     result_o;
    logic                   ready_o;

    modport master (
        output signed_div_i,
        output opdata1_i,
        output opdata2_i,
        output start_i,
        output annul_i,
        input  result_o,
        input  ready_o
    );

    modport slave (
        input  signed_div_i,
        input  opdata1_i,
        input  opdata2_i,
        input  start_i,
        input  annul_i,
        output result_o,
        output ready_o
    );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU, one quotient bit per cycle.
// result_o = {remainder, quotient}; remainder follows the dividend's sign.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus
);

    localparam int                CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] S_FREE   = 2'd0;
    localparam logic [1:0] S_BYZERO = 2'd1;
    localparam logic [1:0] S_ON     = 2'd2;
    localparam logic [1:0] S_END    = 2'd3;

    logic [1:0]           state_q,   state_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [2*WIDTH:0]     work_q,    work_d;
    logic [WIDTH-1:0]     divisor_q, divisor_d;
    logic                 signed_q,  signed_d;
    logic                 dvd_neg_q, dvd_neg_d;
    logic                 dvs_neg_q, dvs_neg_d;
    logic [2*WIDTH-1:0]   result_q,  result_d;
    logic                 ready_q,   ready_d;

    logic                 op1_neg;
    logic                 op2_neg;
    logic [WIDTH-1:0]     op1_mag;
    logic [WIDTH-1:0]     op2_mag;
    logic [WIDTH:0]       trial;
    logic [WIDTH-1:0]     quo_mag;
    logic [WIDTH-1:0]     rem_mag;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;
    logic                 request;

    assign request = bus.start_i & ~bus.annul_i;

    assign op1_neg = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
    assign op2_neg = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
    assign op1_mag = op1_neg ? -bus.opdata1_i : bus.opdata1_i;
    assign op2_mag = op2_neg ? -bus.opdata2_i : bus.opdata2_i;

    // Trial subtraction on the partial remainder; bit WIDTH set means it went negative.
    assign trial = {1'b0, work_q[2*WIDTH-1:WIDTH]} - {1'b0, divisor_q};

    assign quo_mag = work_q[WIDTH-1:0];
    assign rem_mag = work_q[2*WIDTH:WIDTH+1];
    assign quo_fix = (signed_q & (dvd_neg_q ^ dvs_neg_q)) ? -quo_mag : quo_mag;
    assign rem_fix = (signed_q & dvd_neg_q) ? -rem_mag : rem_mag;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        signed_d  = signed_q;
        dvd_neg_d = dvd_neg_q;
        dvs_neg_d = dvs_neg_q;
        result_d  = result_q;
        ready_d   = ready_q;

        case (state_q)
            S_FREE: begin
                ready_d  = 1'b0;
                result_d = '0;
                if (request) begin
                    if (bus.opdata2_i == '0) begin
                        state_d = S_BYZERO;
                    end else begin
                        signed_d  = bus.signed_div_i;
                        dvd_neg_d = op1_neg;
                        dvs_neg_d = op2_neg;
                        divisor_d = op2_mag;
                        work_d    = {{WIDTH{1'b0}}, op1_mag, 1'b0};
                        cnt_d     = '0;
                        state_d   = S_ON;
                    end
                end
            end

            S_BYZERO: begin
                result_d = '0;
                ready_d  = 1'b1;
                state_d  = S_END;
            end

            S_ON: begin
                if (bus.annul_i) begin
                    ready_d  = 1'b0;
                    result_d = '0;
                    state_d  = S_FREE;
                end else if (cnt_q < CNT_LAST) begin
                    if (trial[WIDTH]) begin
                        work_d = {work_q[2*WIDTH-1:0], 1'b0};
                    end else begin
                        work_d = {trial[WIDTH-1:0], work_q[WIDTH-1:0], 1'b1};
                    end
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    result_d = {rem_fix, quo_fix};
                    ready_d  = 1'b1;
                    state_d  = S_END;
                end
            end

            S_END: begin
                if (!bus.start_i) begin
                    ready_d  = 1'b0;
                    result_d = '0;
                    state_d  = S_FREE;
                end
            end

            default: begin
                state_d = S_FREE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FREE;
            cnt_q     <= '0;
            work_q    <= '0;
            divisor_q <= '0;
            signed_q  <= 1'b0;
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            signed_q  <= signed_d;
            dvd_neg_q <= dvd_neg_d;
            dvs_neg_q <= dvs_neg_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, divide by zero,
// annul/reset mid-divide and operand isolation, against hand-computed values.
module tb_div_unit;

    logic clk = 1'b0;
    logic rst;
    int   checkCount = 0;
    int   errorCount = 0;

    always #5 clk = ~clk;

    div_unit_if #(.WIDTH(32)) bus ();

    div_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        bus.annul_i      = 1'b0;
    endtask

    // Start a divide, count edges after the sampling edge until ready_o, check the
    // result, check it holds while start_i stays high, then release and check clear.
    task automatic runDivide(input string tag, input logic sgn, input logic [31:0] a,
                             input logic [31:0] b, input logic [63:0] expResult,
                             input int expLat, input bit scramble);
        int lat = 0;
        applyStimulus(sgn, a, b);
        @(posedge clk); #1;
        while (bus.ready_o !== 1'b1 && lat < 100) begin
            if (scramble && lat == 5) begin
                bus.opdata1_i    = 32'h0000_FFFF;
                bus.opdata2_i    = 32'h0000_0000;
                bus.signed_div_i = ~sgn;
            end
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({tag, " latency"}, 64'(lat), 64'(expLat));
        checkOutput({tag, " result"}, bus.result_o, expResult);
        repeat (2) @(posedge clk);
        #1;
        checkOutput({tag, " hold ready"}, 64'(bus.ready_o), 64'd1);
        checkOutput({tag, " hold result"}, bus.result_o, expResult);
        bus.start_i = 1'b0;
        @(posedge clk); #1;
        checkOutput({tag, " release ready"}, 64'(bus.ready_o), 64'd0);
        checkOutput({tag, " release result"}, bus.result_o, 64'd0);
    endtask

    // Abandon a divide ten cycles into the iteration, by annul_i or by rst.
    task automatic abortTest(input string tag, input bit useReset);
        int rises = 0;
        applyStimulus(1'b0, 32'd1000, 32'd3);
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        if (useReset) rst = 1'b1;
        else          bus.annul_i = 1'b1;
        @(posedge clk); #1;
        rst         = 1'b0;
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        checkOutput({tag, " abort ready"}, 64'(bus.ready_o), 64'd0);
        checkOutput({tag, " abort result"}, bus.result_o, 64'd0);
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.ready_o) rises++;
        end
        checkOutput({tag, " ready never rose"}, 64'(rises), 64'd0);
        runDivide({tag, " fresh ffffffff/1"}, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001,
                  64'h00000000_FFFFFFFF, 33, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int readySeen = 0;
        rst              = 1'b1;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset ready", 64'(bus.ready_o), 64'd0);
        checkOutput("reset result", bus.result_o, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        runDivide("u 100/7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 1'b0);
        runDivide("s -7/2", 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFFFFFF_FFFFFFFD, 33, 1'b0);
        runDivide("s 7/-2", 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, 33, 1'b0);
        runDivide("u fffffff9/2", 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 64'h00000001_7FFFFFFC, 33, 1'b0);
        runDivide("s -100/-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 64'hFFFFFFFE_0000000E, 33, 1'b0);
        runDivide("u 5/0", 1'b0, 32'd5, 32'd0, 64'd0, 1, 1'b0);

        // A request with annul_i high is not a request, even with a zero divisor.
        applyStimulus(1'b0, 32'd5, 32'd0);
        bus.annul_i = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (bus.ready_o) readySeen++;
        end
        checkOutput("annulled request ignored", 64'(readySeen), 64'd0);
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        @(posedge clk); #1;

        abortTest("annul", 1'b0);
        abortTest("reset", 1'b1);

        runDivide("s 80000000/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 33, 1'b0);
        runDivide("u 0/3", 1'b0, 32'd0, 32'd3, 64'd0, 33, 1'b0);
        runDivide("u 3/ffffffff", 1'b0, 32'd3, 32'hFFFF_FFFF, 64'h00000003_00000000, 33, 1'b0);
        runDivide("u 100/7 operands changed", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
